// File: rtl/vga_uart_pkg.sv
// Shared types and constants for the pixel-to-UART byte packer.
// PIXEL_UART_CHECKSUM_EN adds the CKSUM trailer state.
package vga_uart_pkg;

    localparam int unsigned PIXEL_BITS_DEF   = 16;
    localparam int unsigned FRAME_W_DEF      = 640;
    localparam int unsigned FRAME_H_DEF      = 480;
    localparam int unsigned ACTIVE_W_DEF     = 512;
    localparam int unsigned ACTIVE_H_DEF     = 384;
    localparam int unsigned FIFO_DEPTH_DEF   = 16;
    localparam int unsigned BYTES_PER_PIXEL  = PIXEL_BITS_DEF / 8;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PIX_HI,
        ST_PIX_LO
`ifdef PIXEL_UART_CHECKSUM_EN
        , ST_CKSUM
`endif
    } state_e;

endpackage

// File: rtl/pixel_uart_packer_sync_fifo.sv
// Synchronous FIFO with registered full/empty; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rd_data_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    logic [Width-1:0] mem_q [Depth];

    always_comb begin : ptr_comb
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        full_d   = (count_d == CntW'(Depth));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin : ptr_regs
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin : mem_write
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/pixel_uart_packer.sv
// Crops incoming pixel words to the active window, buffers them and serializes
// them as bytes with a per-frame A5/5A header. PIXEL_UART_CHECKSUM_EN adds an XOR trailer.
module pixel_uart_packer
    import vga_uart_pkg::*;
#(
    parameter int unsigned PixelBitWidth     = PIXEL_BITS_DEF,
    parameter int unsigned FrameWidth        = FRAME_W_DEF,
    parameter int unsigned FrameHeight       = FRAME_H_DEF,
    parameter int unsigned ActiveFrameWidth  = ACTIVE_W_DEF,
    parameter int unsigned ActiveFrameHeight = ACTIVE_H_DEF,
    parameter int unsigned FifoDepth         = FIFO_DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [PixelBitWidth-1:0] i_pixel,
    input  logic                     i_valid,
    input  logic                     i_frame_start,
    output logic [7:0]               o_byte,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_frame_done,
    output logic                     o_overflow
);

    localparam int unsigned ColW     = $clog2(FrameWidth);
    localparam int unsigned RowW     = $clog2(FrameHeight + 1);
    localparam int unsigned TotalPix = ActiveFrameWidth * ActiveFrameHeight;
    localparam int unsigned EmitW    = $clog2(TotalPix + 1);

    state_e                   state_q, state_d;
    logic [ColW-1:0]          col_q, col_d, cur_col;
    logic [RowW-1:0]          row_q, row_d, cur_row;
    logic [EmitW-1:0]         emit_q, emit_d, emit_inc;
    logic                     hdr_pending_q, hdr_pending_d;
    logic [7:0]               o_byte_q, o_byte_d;
    logic [7:0]               lo_byte_q, lo_byte_d;
    logic                     o_valid_q, o_valid_d;
    logic                     frame_done_q, frame_done_d;
    logic                     overflow_q, overflow_d;
`ifdef PIXEL_UART_CHECKSUM_EN
    logic [7:0]               xor_q, xor_d;
`endif

    logic                     active, push_req, push_ok;
    logic                     fifo_pop, fifo_full, fifo_empty;
    logic [PixelBitWidth-1:0] fifo_rdata;
    logic                     xfer, load_next;

    // Position tracking and crop; a frame start re-bases the same-cycle pixel to (0,0).
    always_comb begin : input_comb
        cur_col    = i_frame_start ? '0 : col_q;
        cur_row    = i_frame_start ? '0 : row_q;
        col_d      = cur_col;
        row_d      = cur_row;
        active     = (32'(cur_col) < ActiveFrameWidth) && (32'(cur_row) < ActiveFrameHeight);
        push_req   = i_valid && active;
        push_ok    = push_req && (!fifo_full || fifo_pop);
        overflow_d = overflow_q || (push_req && !push_ok);
        if (i_valid) begin
            if (cur_col == ColW'(FrameWidth - 1)) begin
                col_d = '0;
                row_d = (cur_row == RowW'(FrameHeight)) ? cur_row : cur_row + RowW'(1);
            end else begin
                col_d = cur_col + ColW'(1);
            end
        end
    end

    sync_fifo #(
        .Width (PixelBitWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_ok),
        .wdata     (i_pixel),
        .pop       (fifo_pop),
        .rd_data_c (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign xfer = o_valid_q && i_ready;

    always_comb begin : fsm_comb
        state_d       = state_q;
        o_byte_d      = o_byte_q;
        o_valid_d     = o_valid_q;
        lo_byte_d     = lo_byte_q;
        emit_d        = emit_q;
        emit_inc      = emit_q + EmitW'(1);
        frame_done_d  = 1'b0;
        hdr_pending_d = hdr_pending_q || i_frame_start;
        fifo_pop      = 1'b0;
        load_next     = 1'b0;
`ifdef PIXEL_UART_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        unique case (state_q)
            ST_IDLE: load_next = 1'b1;
            ST_HDR0: begin
                if (xfer) begin
                    state_d  = ST_HDR1;
                    o_byte_d = SYNC1;
                end
            end
            ST_HDR1: load_next = xfer;
            ST_PIX_HI: begin
                if (xfer) begin
                    state_d  = ST_PIX_LO;
                    o_byte_d = lo_byte_q;
`ifdef PIXEL_UART_CHECKSUM_EN
                    xor_d    = xor_q ^ o_byte_q;
`endif
                end
            end
            ST_PIX_LO: begin
                if (xfer) begin
                    emit_d = emit_inc;
`ifdef PIXEL_UART_CHECKSUM_EN
                    xor_d  = xor_q ^ o_byte_q;
                    if (emit_inc == EmitW'(TotalPix)) begin
                        emit_d   = '0;
                        state_d  = ST_CKSUM;
                        o_byte_d = xor_q ^ o_byte_q;
                    end else begin
                        load_next = 1'b1;
                    end
`else
                    if (emit_inc == EmitW'(TotalPix)) begin
                        emit_d       = '0;
                        frame_done_d = 1'b1;
                    end
                    load_next = 1'b1;
`endif
                end
            end
`ifdef PIXEL_UART_CHECKSUM_EN
            ST_CKSUM: begin
                if (xfer) begin
                    frame_done_d = 1'b1;
                    load_next    = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Pick the next byte source without a bubble; leftover pixels drain before the header.
        if (load_next) begin
            if (hdr_pending_q && fifo_empty) begin
                state_d       = ST_HDR0;
                o_byte_d      = SYNC0;
                o_valid_d     = 1'b1;
                hdr_pending_d = i_frame_start;
                emit_d        = '0;
`ifdef PIXEL_UART_CHECKSUM_EN
                xor_d         = '0;
`endif
            end else if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                state_d   = ST_PIX_HI;
                o_byte_d  = fifo_rdata[PixelBitWidth-1 -: 8];
                lo_byte_d = fifo_rdata[7:0];
                o_valid_d = 1'b1;
            end else begin
                state_d   = ST_IDLE;
                o_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin : regs
        if (RST) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            emit_q        <= '0;
            hdr_pending_q <= 1'b0;
            o_byte_q      <= '0;
            lo_byte_q     <= '0;
            o_valid_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef PIXEL_UART_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            emit_q        <= emit_d;
            hdr_pending_q <= hdr_pending_d;
            o_byte_q      <= o_byte_d;
            lo_byte_q     <= lo_byte_d;
            o_valid_q     <= o_valid_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
`ifdef PIXEL_UART_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

    assign o_byte       = o_byte_q;
    assign o_valid      = o_valid_q;
    assign o_frame_done = frame_done_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_uart_packer.sv
// Directed self-checking bench for pixel_uart_packer; instance A (24x4 in 32x8),
// instance B (4x2 in 8x4), and with PIXEL_UART_CHECKSUM_EN instance C (2x1 in 4x2).
module tb_pixel_uart_packer;

    logic        clk, rst;
    logic [15:0] s_pix;
    logic        s_vld, s_fs, s_rdy;
    int          sel;

    logic [7:0]  a_byte, b_byte;
    logic        a_val, b_val, a_done, b_done, a_ovf, b_ovf;
    logic [7:0]  m_byte;
    logic        m_val, m_done, m_ovf;
`ifdef PIXEL_UART_CHECKSUM_EN
    logic [7:0]  c_byte;
    logic        c_val, c_done, c_ovf;
`endif

    int          n_checks, n_err, cyc, done_cnt, done_cyc;
    logic [7:0]  got[$];
    int          gcyc[$];
    logic [7:0]  exp_q[$];

    pixel_uart_packer #(
        .FrameWidth(32), .FrameHeight(8), .ActiveFrameWidth(24),
        .ActiveFrameHeight(4), .FifoDepth(16)
    ) u_a (
        .CLK(clk), .RST(rst), .i_pixel(s_pix), .i_valid(s_vld && sel == 0),
        .i_frame_start(s_fs && sel == 0), .o_byte(a_byte), .o_valid(a_val),
        .i_ready(s_rdy && sel == 0), .o_frame_done(a_done), .o_overflow(a_ovf)
    );

    pixel_uart_packer #(
        .FrameWidth(8), .FrameHeight(4), .ActiveFrameWidth(4),
        .ActiveFrameHeight(2), .FifoDepth(16)
    ) u_b (
        .CLK(clk), .RST(rst), .i_pixel(s_pix), .i_valid(s_vld && sel == 1),
        .i_frame_start(s_fs && sel == 1), .o_byte(b_byte), .o_valid(b_val),
        .i_ready(s_rdy && sel == 1), .o_frame_done(b_done), .o_overflow(b_ovf)
    );

`ifdef PIXEL_UART_CHECKSUM_EN
    pixel_uart_packer #(
        .FrameWidth(4), .FrameHeight(2), .ActiveFrameWidth(2),
        .ActiveFrameHeight(1), .FifoDepth(16)
    ) u_c (
        .CLK(clk), .RST(rst), .i_pixel(s_pix), .i_valid(s_vld && sel == 2),
        .i_frame_start(s_fs && sel == 2), .o_byte(c_byte), .o_valid(c_val),
        .i_ready(s_rdy && sel == 2), .o_frame_done(c_done), .o_overflow(c_ovf)
    );
`endif

    always_comb begin
        m_byte = a_byte; m_val = a_val; m_done = a_done; m_ovf = a_ovf;
        if (sel == 1) begin
            m_byte = b_byte; m_val = b_val; m_done = b_done; m_ovf = b_ovf;
        end
`ifdef PIXEL_UART_CHECKSUM_EN
        if (sel == 2) begin
            m_byte = c_byte; m_val = c_val; m_done = c_done; m_ovf = c_ovf;
        end
`endif
    end

    always #5 clk = ~clk;

    // Byte capture mid-cycle: a byte shown with valid&&ready transfers at the next edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_val && s_rdy) begin
            got.push_back(m_byte);
            gcyc.push_back(cyc);
        end
        if (m_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        s_fs = 1'b1;
        tick();
        s_fs = 1'b0;
    endtask

    task automatic send(input logic [15:0] p, input int gap);
        s_pix = p;
        s_vld = 1'b1;
        tick();
        s_vld = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear();
        got.delete();
        gcyc.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? 32'(got[i]) : 32'hFFFF;
    endfunction

    task automatic check_bytes(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), got_at(i), 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0]  e1 [10];
        logic [15:0] p;
        logic [7:0]  x;
        int          found;
        e1 = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
        clk = 1'b0; rst = 1'b1; sel = 0;
        s_pix = '0; s_vld = 1'b0; s_fs = 1'b0; s_rdy = 1'b0;
        n_checks = 0; n_err = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
        repeat (2) tick();
        chk("rst_valid", 32'(m_val), 0);
        chk("rst_byte", 32'(m_byte), 0);
        chk("rst_done", 32'(m_done), 0);
        chk("rst_ovf", 32'(m_ovf), 0);
        rst = 1'b0;
        tick();

        // Header then four pixels streamed at one byte per cycle
        clear();
        s_rdy = 1'b1;
        frame_start();
        send(16'h1234, 0); send(16'hABCD, 0); send(16'h0001, 0); send(16'hFF00, 0);
        repeat (20) tick();
        for (int i = 0; i < 10; i++) exp_q.push_back(e1[i]);
        check_bytes("basic");
        chk("basic_rate", (gcyc.size() == 10) ? 32'(gcyc[9] - gcyc[0]) : 32'hFFFF, 9);

        // Remaining active columns of row 0, then the cropped columns 24..31
        clear();
        for (int c = 4; c < 24; c++) send(16'h2000 + 16'(c), 1);
        repeat (10) tick();
        chk("row0_active_bytes", 32'(got.size()), 40);
        clear();
        for (int c = 24; c < 32; c++) send(16'h2100 + 16'(c), 1);
        repeat (10) tick();
        chk("col_crop_bytes", 32'(got.size()), 0);

        // Rows 1..3 complete the 96-pixel active frame
        clear();
        for (int r = 1; r < 4; r++)
            for (int c = 0; c < 32; c++) send(16'h3000 + 16'(r * 32 + c), 1);
        repeat (10) tick();
        chk("rows13_bytes", 32'(got.size()), 144);
        chk("frameA_done_cnt", 32'(done_cnt), 1);
        chk("frameA_done_timing", 32'(done_cyc), (gcyc.size() > 0) ? 32'(gcyc[$] + 1) : 32'hFFFF);

        // Rows 4..7 and the saturated row beyond are all cropped
        clear();
        for (int i = 0; i < 4 * 32 + 8; i++) send(16'h4000 + 16'(i), 0);
        repeat (10) tick();
        chk("row_crop_bytes", 32'(got.size()), 0);
        chk("row_crop_ovf", 32'(m_ovf), 0);

        // Stalled sink: header holds, 16 pixels buffer, the 17th is dropped
        clear();
        s_rdy = 1'b0;
        frame_start();
        for (int i = 0; i < 16; i++) send({8'(i + 16), 8'(8'hC0 ^ i)}, 0);
        repeat (2) tick();
        chk("stall_ovf_before", 32'(m_ovf), 0);
        chk("stall_valid", 32'(m_val), 1);
        chk("stall_byte", 32'(m_byte), 32'hA5);
        send(16'hDEAD, 0);
        tick();
        chk("stall_ovf_after", 32'(m_ovf), 1);
        chk("stall_byte_held", 32'(m_byte), 32'hA5);
        s_rdy = 1'b1;
        repeat (50) tick();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i + 16));
            exp_q.push_back(8'(8'hC0 ^ i));
        end
        check_bytes("stall");
        chk("stall_ovf_sticky", 32'(m_ovf), 1);

        // Asynchronous reset while the low byte is on the wire
        clear();
        frame_start();
        send(16'hBEEF, 0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (m_val && m_byte == 8'hEF) found = 1;
        end
        chk("rst_reach_pix_lo", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(m_val), 0);
        chk("rst_async_byte", 32'(m_byte), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ovf_cleared", 32'(m_ovf), 0);
        clear();
        frame_start();
        send(16'h4242, 0);
        repeat (10) tick();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h42); exp_q.push_back(8'h42);
        check_bytes("post_rst");

        // Instance B: whole 8x4 frame, 4x2 kept, one frame-done pulse
        sel = 1;
        clear();
        frame_start();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        x = 8'h00;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                p = {8'(r * 8 + c), 8'(8'h80 ^ (r * 8 + c))};
                if (c < 4 && r < 2) begin
                    exp_q.push_back(p[15:8]);
                    exp_q.push_back(p[7:0]);
                    x = x ^ p[15:8] ^ p[7:0];
                end
                send(p, 1);
            end
`ifdef PIXEL_UART_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        repeat (20) tick();
        check_bytes("frameB");
        chk("frameB_done_cnt", 32'(done_cnt), 1);
        chk("frameB_done_timing", 32'(done_cyc), (gcyc.size() > 0) ? 32'(gcyc[$] + 1) : 32'hFFFF);

`ifdef PIXEL_UART_CHECKSUM_EN
        // Instance C: 2x1 window, checksum trailer 0F^0F^00^FF
        sel = 2;
        clear();
        frame_start();
        send(16'h0F0F, 0);
        send(16'h00FF, 0);
        repeat (15) tick();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        check_bytes("cksum");
        chk("cksum_done_cnt", 32'(done_cnt), 1);
        chk("cksum_done_timing", 32'(done_cyc), (gcyc.size() > 0) ? 32'(gcyc[$] + 1) : 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
